// File: rtl/dm_access_ctrl.sv
// Data-memory initiator: load/store requests in, memory pins out, extended load data back (RMW merge with DM_RMW_MERGE_EN).
// Latency: accept T, memory access T+1, resp_valid T+2 (sub-word store with DM_RMW_MERGE_EN: T+4).
// Backpressure: req_ready only in IDLE; resp_valid is an unstallable one-cycle pulse.
module dm_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    output logic [1:0]        dm_mode,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
`ifdef DM_RMW_MERGE_EN
        S_RMW_RD,
        S_RMW_WR,
`endif
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_req_rdy;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_err;
    logic              r_resp_vld;
    logic              r_resp_err;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [31:0]       r_dm_din;
    logic              r_dm_we;
    logic [1:0]        r_dm_mode;

    logic              w_err;
    logic              w_issue_we;
    logic [1:0]        w_issue_mode;
    logic [31:0]       w_ext;

    always_comb begin
        w_err = (req_size == 2'b11)
             || (req_size == 2'b10 && req_addr[0])
             || (req_size == 2'b00 && req_addr[1:0] != 2'b00);
    end

`ifdef DM_RMW_MERGE_EN
    logic        w_rmw;
    logic [31:0] w_merge;

    // Sub-word stores start with a plain word read; the write happens after the merge.
    always_comb begin
        w_issue_we   = req_we && !w_err && (req_size == 2'b00);
        w_issue_mode = (w_err || req_we) ? 2'b00 : req_size;
        w_rmw        = r_we && !r_err && (r_size != 2'b00);
    end

    always_comb begin
        w_merge = dm_dout;
        if (r_size == 2'b01) begin
            w_merge[{r_dm_addr[1:0], 3'b000} +: 8] = r_dm_din[7:0];
        end else begin
            w_merge[{r_dm_addr[1], 4'b0000} +: 16] = r_dm_din[15:0];
        end
    end
`else
    always_comb begin
        w_issue_we   = req_we && !w_err;
        w_issue_mode = w_err ? 2'b00 : req_size;
    end
`endif

    always_comb begin
        case (r_size)
            2'b01:   w_ext = {{24{r_signed & dm_dout[7]}}, dm_dout[7:0]};
            2'b10:   w_ext = {{16{r_signed & dm_dout[15]}}, dm_dout[15:0]};
            default: w_ext = dm_dout;
        endcase
    end

    // Read data is only meaningful during the response pulse of a clean load.
    assign resp_rdata = (r_resp_vld && !r_we && !r_err) ? w_ext : 32'h0;
    assign req_ready  = r_req_rdy;
    assign resp_valid = r_resp_vld;
    assign resp_err   = r_resp_err;
    assign dm_addr    = r_dm_addr;
    assign dm_din     = r_dm_din;
    assign dm_we      = r_dm_we;
    assign dm_mode    = r_dm_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req_rdy  <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_err      <= 1'b0;
            r_resp_vld <= 1'b0;
            r_resp_err <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_din   <= 32'h0;
            r_dm_we    <= 1'b0;
            r_dm_mode  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_rdy <= 1'b1;
                    if (req_valid && r_req_rdy) begin
                        r_req_rdy <= 1'b0;
                        r_we      <= req_we;
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        r_err     <= w_err;
                        r_dm_addr <= req_addr;
                        r_dm_din  <= req_wdata;
                        r_dm_we   <= w_issue_we;
                        r_dm_mode <= w_issue_mode;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_dm_we   <= 1'b0;
                    r_dm_mode <= 2'b00;
`ifdef DM_RMW_MERGE_EN
                    if (w_rmw) begin
                        r_state <= S_RMW_RD;
                    end else begin
                        r_resp_vld <= 1'b1;
                        r_resp_err <= r_err;
                        r_state    <= S_RESP;
                    end
`else
                    r_resp_vld <= 1'b1;
                    r_resp_err <= r_err;
                    r_state    <= S_RESP;
`endif
                end
`ifdef DM_RMW_MERGE_EN
                S_RMW_RD: begin
                    r_dm_we  <= 1'b1;
                    r_dm_din <= w_merge;
                    r_state  <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_dm_we    <= 1'b0;
                    r_resp_vld <= 1'b1;
                    r_resp_err <= r_err;
                    r_state    <= S_RESP;
                end
`endif
                S_RESP: begin
                    r_resp_vld <= 1'b0;
                    r_resp_err <= 1'b0;
                    r_req_rdy  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_dm_we   <= 1'b0;
                    r_dm_mode <= 2'b00;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural registered-read data memory.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [1:0]  dm_mode;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_a;
    logic [31:0] bd_d;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int mode3_cnt = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_mode(dm_mode), .dm_dout(dm_dout)
    );

    // Memory: sub-word writes zero unselected lanes, sub-word reads return the lane low-justified.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_a] <= bd_d;
        end else if (dm_we) begin
            case (dm_mode)
                2'b01: begin
                    mem[dm_addr[11:2]] <= 32'h0;
                    mem[dm_addr[11:2]][8*dm_addr[1:0] +: 8] <= dm_din[7:0];
                end
                2'b10: begin
                    mem[dm_addr[11:2]] <= 32'h0;
                    mem[dm_addr[11:2]][16*dm_addr[1] +: 16] <= dm_din[15:0];
                end
                default: mem[dm_addr[11:2]] <= dm_din;
            endcase
        end else begin
            case (dm_mode)
                2'b01: dm_dout <= {24'h0, mem[dm_addr[11:2]][8*dm_addr[1:0] +: 8]};
                2'b10: dm_dout <= {16'h0, mem[dm_addr[11:2]][16*dm_addr[1] +: 16]};
                2'b11: begin
                    mem[dm_addr[11:2]] <= 32'h0;
                    dm_dout <= 32'h0;
                end
                default: dm_dout <= mem[dm_addr[11:2]];
            endcase
        end
    end

    always @(negedge clk) begin
        if (dm_we) we_cnt <= we_cnt + 1;
        if (dm_mode == 2'b11) mode3_cnt <= mode3_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bd(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_a = a[11:2]; bd_d = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One request; returns cycles from accept to resp_valid plus the response fields.
    task automatic xfer(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [11:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ready_low_after_accept", {31'h0, req_ready}, 32'h0);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1;
        chk("resp_single_pulse", {31'h0, resp_valid}, 32'h0);
        chk("ready_after_resp", {31'h0, req_ready}, 32'h1);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          snap;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
        bd_we = 1'b0; bd_a = 10'h0; bd_d = 32'h0;

        #2;
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_dm_pins", {17'h0, dm_addr, dm_we, dm_mode}, 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("ready_after_first_edge", {31'h0, req_ready}, 32'h1);

        // Word store then word load
        xfer(1'b1, 2'b00, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd, er);
        chk("wst_lat", 32'(lat), 32'd2);
        chk("wst_err_rdata", {er, rd[30:0]}, 32'h0);
        chk("wst_mem", mem[4], 32'hDEADBEEF);
        xfer(1'b0, 2'b00, 1'b0, 12'h010, 32'h0, lat, rd, er);
        chk("wld_lat", 32'(lat), 32'd2);
        chk("wld_rdata", rd, 32'hDEADBEEF);
        chk("wld_err", {31'h0, er}, 32'h0);

        // Byte loads
        bd(12'h020, 32'h12345680);
        xfer(1'b0, 2'b01, 1'b1, 12'h020, 32'h0, lat, rd, er);
        chk("bld_s_rdata", rd, 32'hFFFFFF80);
        chk("bld_s_lat", 32'(lat), 32'd2);
        xfer(1'b0, 2'b01, 1'b0, 12'h020, 32'h0, lat, rd, er);
        chk("bld_u_rdata", rd, 32'h00000080);
        xfer(1'b0, 2'b01, 1'b1, 12'h021, 32'h0, lat, rd, er);
        chk("bld_s_lane1", rd, 32'h00000056);

        // Half loads
        bd(12'h030, 32'h80011234);
        xfer(1'b0, 2'b10, 1'b1, 12'h032, 32'h0, lat, rd, er);
        chk("hld_s_rdata", rd, 32'hFFFF8001);
        xfer(1'b0, 2'b10, 1'b0, 12'h032, 32'h0, lat, rd, er);
        chk("hld_u_rdata", rd, 32'h00008001);
        xfer(1'b0, 2'b10, 1'b1, 12'h030, 32'h0, lat, rd, er);
        chk("hld_s_low", rd, 32'h00001234);

        // Misaligned and illegal accesses
        snap = we_cnt;
        xfer(1'b0, 2'b10, 1'b1, 12'h033, 32'h0, lat, rd, er);
        chk("mis_hld_err", {31'h0, er}, 32'h1);
        chk("mis_hld_rdata", rd, 32'h0);
        chk("mis_hld_lat", 32'(lat), 32'd2);
        xfer(1'b1, 2'b00, 1'b0, 12'h012, 32'hCAFEF00D, lat, rd, er);
        chk("mis_wst_err", {31'h0, er}, 32'h1);
        chk("mis_wst_rdata", rd, 32'h0);
        xfer(1'b1, 2'b10, 1'b0, 12'h031, 32'h00005555, lat, rd, er);
        chk("mis_hst_err", {31'h0, er}, 32'h1);
        xfer(1'b0, 2'b11, 1'b0, 12'h020, 32'h0, lat, rd, er);
        chk("ill_ld_err", {31'h0, er}, 32'h1);
        chk("ill_ld_rdata", rd, 32'h0);
        xfer(1'b1, 2'b11, 1'b0, 12'h020, 32'h77777777, lat, rd, er);
        chk("ill_st_err", {31'h0, er}, 32'h1);
        chk("err_no_write", 32'(we_cnt - snap), 32'd0);
        chk("err_mem_010", mem[4], 32'hDEADBEEF);
        chk("err_mem_020", mem[8], 32'h12345680);
        chk("err_mem_030", mem[12], 32'h80011234);
        chk("mode3_never", 32'(mode3_cnt), 32'd0);

        // Sub-word stores
        bd(12'h040, 32'h11223344);
        xfer(1'b1, 2'b01, 1'b0, 12'h041, 32'h000000AB, lat, rd, er);
        chk("bst_err", {31'h0, er}, 32'h0);
        bd(12'h044, 32'hAABBCCDD);
        snap = lat;
        xfer(1'b1, 2'b10, 1'b0, 12'h046, 32'hFFFFBEEF, lat, rd, er);
`ifdef DM_RMW_MERGE_EN
        chk("bst_mem", mem[16], 32'h1122AB44);
        chk("bst_lat", 32'(snap), 32'd4);
        chk("hst_mem", mem[17], 32'hBEEFCCDD);
        chk("hst_lat", 32'(lat), 32'd4);
`else
        chk("bst_mem", mem[16], 32'h0000AB00);
        chk("bst_lat", 32'(snap), 32'd2);
        chk("hst_mem", mem[17], 32'hBEEF0000);
        chk("hst_lat", 32'(lat), 32'd2);
`endif

        // Reset during the ISSUE cycle of a word store
        bd(12'h050, 32'h01020304);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 12'h050; req_wdata = 32'h55667788;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midop_issue_we", {31'h0, dm_we}, 32'h1);
        snap = resp_cnt;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midop_we_drop", {29'h0, dm_we, dm_mode}, 32'h0);
        chk("midop_ready_low", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("midop_no_resp", 32'(resp_cnt - snap), 32'd0);
        chk("midop_mem", mem[20], 32'h01020304);
        xfer(1'b0, 2'b00, 1'b0, 12'h050, 32'h0, lat, rd, er);
        chk("post_rst_load", rd, 32'h01020304);
        chk("mode3_final", 32'(mode3_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory port.
- Accepts load/store requests from the pipeline over a valid/ready handshake and drives the data memory's address, write-data, write-enable and size-mode pins.
- For loads, captures the memory's registered read data and sign- or zero-extends it.
- Flags misaligned or illegal accesses, and never issues those to memory.

Parameters:
- ADDR_W, 12, byte-address width; memory word index is addr[ADDR_W-1:2], byte lane is addr[1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 word, 01 byte, 10 half, 11 illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned/illegal; valid with resp_valid
- dm_addr  out  ADDR_W  memory address
- dm_din  out  32  memory write data
- dm_we  out  1  memory write enable
- dm_mode  out  2  memory size mode: 00 word, 01 byte, 10 half
- dm_dout  in  32  memory read data; registered, valid the cycle after a read is issued

Behaviour:
- Reset is asynchronous. While rst_n=0, all outputs are 0 except req_ready=0.
  - dm_we=0 and dm_mode=00 take effect immediately.
  - Any in-flight request is dropped; no resp_valid is generated for it.
  - req_ready=1 from the first clock edge after rst_n deasserts.
- States: IDLE, ISSUE, RESP (plus RMW_RD and RMW_WR when the optional feature is compiled in).
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register we/size/signed/addr/wdata and go to ISSUE.
  - Requests are ignored in every other state (req_ready=0).
- Error check, done at accept: resp_err=1 when any of the following holds:
  - size=11;
  - size=10 and addr[0]=1;
  - size=00 and addr[1:0]!=00.
- Errored request: ISSUE drives dm_we=0, dm_mode=00, and goes to RESP with resp_err=1 and resp_rdata=0.
- ISSUE, legal request:
  - dm_addr = registered addr.
  - dm_mode = size.
  - dm_we = we.
  - dm_din = wdata.
  - Next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Load: resp_rdata is taken from dm_dout in that same cycle.
  - Next state is IDLE.
- Latency: accept edge T, memory access in T+1, resp_valid in T+2, req_ready=1 again in T+3.
  - Sustained throughput is 1 request per 3 cycles.
- Load extension (memory returns the selected byte or half in the low bits, zero-filled above):
  - byte: signed gives [31:8]=dout[7], unsigned gives [31:8]=0.
  - half: signed gives [31:16]=dout[15], unsigned gives [31:16]=0.
  - word: dout passed through unchanged.
- Outside ISSUE/RMW_WR, dm_we=0 and dm_mode=00.
  - mode 11 must never appear, because the memory clears the addressed word when it sees mode 11 on a read.
- resp_valid is a pulse with no back-pressure; the requester must sample it.
- Sub-word store without the optional feature: the memory zeroes the unselected lanes of the addressed word. This is the specified behaviour.

Optional Feature:
- Macro: DM_RMW_MERGE_EN.
- Defined:
  - Legal byte/half stores go ISSUE→RMW_RD→RMW_WR→RESP instead of ISSUE→RESP.
  - ISSUE drives a word read: dm_we=0, mode=00.
  - RMW_RD is idle on the pins and waits for dm_dout.
  - RMW_WR drives dm_we=1, mode=00, dm_din = dm_dout with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Sub-word store latency becomes 4 cycles, so resp_valid appears at T+4.
  - Word stores and all loads are unchanged.
- Undefined: sub-word stores are issued directly with mode=size, in 2 cycles.

Test Plan:
- Reset mid-op: assert rst_n=0 in the ISSUE cycle of a store -> dm_we drops immediately, no resp_valid, and memory is unmodified.
- Word store then load: store 0xDEADBEEF @0x010, then load word @0x010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at T+2 for both.
- Signed byte load: memory word 0x12345680 @0x020, load byte signed @0x020 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Signed half load: word 0x8001xxxx @0x030, load half signed @0x032 -> 0xFFFF8001.
- Misaligned: load half @0x033 and store word @0x012 -> resp_err=1, resp_rdata=0, dm_we never 1, target words unchanged; size=11 -> resp_err=1, dm_mode never 11.
- Byte store 0xAB @0x041 over 0x11223344:
  - without DM_RMW_MERGE_EN -> word reads 0x0000AB00;
  - with DM_RMW_MERGE_EN -> word reads 0x1122AB44, resp_valid at T+4.
